// File: rtl/jpeg_pkg.sv
// jpeg_pkg: constants and zigzag lookup tables shared by the zigzag buffer.
//   COEF_W    - quantized coefficient width in bits
//   BLK_ROWS  - rows (and columns) in an 8x8 block
//   zz_addr() - zigzag position -> raster address (row*8 + col)
//   zz_pos()  - raster address -> zigzag position
package jpeg_pkg;

  localparam int COEF_W   = 8;
  localparam int BLK_ROWS = 8;

  // Index = zigzag position, value = raster address.
  localparam logic [0:63][5:0] ZZ_TABLE = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Index = raster address, value = zigzag position.
  localparam logic [0:63][5:0] IZZ_TABLE = {
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_addr(input logic [5:0] pos);
    return ZZ_TABLE[pos];
  endfunction

  function automatic logic [5:0] zz_pos(input logic [5:0] addr);
    return IZZ_TABLE[addr];
  endfunction

endpackage

// File: rtl/zz_bank_ctrl.sv
// zz_bank_ctrl: ping-pong bank bookkeeping for the zigzag buffer.
// Holds one full flag per bank plus the write-row and read-index counters.
//   clk, reset       - clock, async active-low reset
//   in_valid         - upstream row present
//   out_ready        - downstream accepts a coefficient
//   in_ready         - write bank has room
//   out_valid        - read bank holds a complete block
//   wr_fire, rd_fire - row / coefficient transfer this cycle
//   wr_bank, wr_row  - bank and row the next row lands in
//   rd_bank, rd_idx  - bank and zigzag position being emitted
//
// Per-bank state (derived from full flag and counters):
//   state    | meaning
//   EMPTY    | !full, not the write bank or wr_row==0
//   FILLING  | !full, write bank, wr_row 1..7
//   FULL     | full, read index not yet moved into it
//   DRAINING | full, read bank, rd_idx 1..63
module zz_bank_ctrl
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       wr_fire,
  output logic       rd_fire,
  output logic       wr_bank,
  output logic [2:0] wr_row,
  output logic       rd_bank,
  output logic [5:0] rd_idx
);

  logic [1:0] full_q;
  logic [1:0] full_d;
  logic       wr_last;
  logic       rd_last;

  assign in_ready  = !full_q[wr_bank];
  assign out_valid = full_q[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_last   = wr_fire && (wr_row == 3'(BLK_ROWS - 1));
  assign rd_last   = rd_fire && (rd_idx == 6'd63);

  // A set and a clear in the same cycle always target different banks:
  // writing needs the write bank empty, reading needs the read bank full.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank] = 1'b1;
    if (rd_last) full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q  <= '0;
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) wr_row <= wr_row + 3'd1;
      if (wr_last) wr_bank <= ~wr_bank;
      if (rd_fire) rd_idx <= rd_idx + 6'd1;
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: rtl/zigzag_buffer.sv
// zigzag_buffer: collects 8 quantized rows into one of two ping-pong banks
// and emits the 64 coefficients in JPEG zigzag order, one per beat.
//   clk, reset     - clock, async active-low reset
//   in_valid/in_ready/in - row beat, column 0 in the top byte
//   out_valid/out_ready  - coefficient handshake
//   out            - coefficient, passed through unchanged
//   out_index      - zigzag position of the current beat
//   out_last       - high on position 63
// Optional build macro ZZ_LAST_NZ_EN adds out_last_nz (highest zigzag
// position holding a nonzero coefficient) and out_all_zero for the block
// being emitted; both are 0 when out_valid is low.
module zigzag_buffer
  import jpeg_pkg::*;
#(
  parameter int COEF_W = jpeg_pkg::COEF_W,
  parameter int NBANK  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BLK_ROWS*COEF_W-1:0] in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COEF_W-1:0]          out,
  output logic [5:0]                 out_index,
`ifdef ZZ_LAST_NZ_EN
  output logic [5:0]                 out_last_nz,
  output logic                       out_all_zero,
`endif
  output logic                       out_last
);

  // Element BLK_ROWS-1 is column 0, matching the row's byte order.
  typedef logic [BLK_ROWS-1:0][COEF_W-1:0] row_t;

  row_t       row_mem [NBANK][BLK_ROWS];
  row_t       in_row;
  row_t       rd_row;
  logic [5:0] rd_addr;

  logic       wr_fire;
  logic       rd_fire;
  logic       wr_bank;
  logic [2:0] wr_row;
  logic       rd_bank;
  logic [5:0] rd_idx;

  assign in_row = in;

  zz_bank_ctrl u_bank_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .wr_fire   (wr_fire),
    .rd_fire   (rd_fire),
    .wr_bank   (wr_bank),
    .wr_row    (wr_row),
    .rd_bank   (rd_bank),
    .rd_idx    (rd_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < BLK_ROWS; r++) begin
          row_mem[b][r] <= '0;
        end
      end
    end else if (wr_fire) begin
      row_mem[wr_bank][wr_row] <= in_row;
    end
  end

  // Raster address splits into row (upper 3 bits) and column (lower 3);
  // column c lives in element 7-c, i.e. the bitwise inverse.
  assign rd_addr   = zz_addr(rd_idx);
  assign rd_row    = row_mem[rd_bank][rd_addr[5:3]];
  assign out       = rd_row[~rd_addr[2:0]];
  assign out_index = rd_idx;
  assign out_last  = out_valid && (rd_idx == 6'd63);

`ifdef ZZ_LAST_NZ_EN
  logic [5:0]       last_nz_q [NBANK];
  logic [NBANK-1:0] nz_seen_q;
  logic [5:0]       row_max;
  logic             row_nz;
  logic [5:0]       col_pos;

  // Highest zigzag position among the nonzero columns of the incoming row.
  always_comb begin
    row_max = '0;
    row_nz  = 1'b0;
    col_pos = '0;
    for (int c = 0; c < BLK_ROWS; c++) begin
      col_pos = zz_pos({wr_row, 3'(c)});
      if (in_row[BLK_ROWS-1-c] != '0) begin
        row_nz = 1'b1;
        if (col_pos > row_max) row_max = col_pos;
      end
    end
  end

  // Row 0 restarts the tracking so a recycled bank forgets its old block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANK; b++) begin
        last_nz_q[b] <= '0;
      end
      nz_seen_q <= '0;
    end else if (wr_fire) begin
      if (wr_row == 3'd0) begin
        last_nz_q[wr_bank] <= row_max;
        nz_seen_q[wr_bank] <= row_nz;
      end else begin
        if (row_max > last_nz_q[wr_bank]) last_nz_q[wr_bank] <= row_max;
        nz_seen_q[wr_bank] <= nz_seen_q[wr_bank] | row_nz;
      end
    end
  end

  assign out_last_nz  = out_valid ? last_nz_q[rd_bank] : '0;
  assign out_all_zero = out_valid && !nz_seen_q[rd_bank];
`endif

endmodule

// File: tb/tb_zigzag_buffer.sv
module tb_zigzag_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic [5:0]  out_index;
  logic        out_last;
`ifdef ZZ_LAST_NZ_EN
  logic [5:0]  out_last_nz;
  logic        out_all_zero;
`endif

  int errors = 0;
  int checks = 0;
  int zz_ref [64];

  always #5 clk = ~clk;

  zigzag_buffer #(.COEF_W(8), .NBANK(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_index (out_index),
`ifdef ZZ_LAST_NZ_EN
    .out_last_nz  (out_last_nz),
    .out_all_zero (out_all_zero),
`endif
    .out_last  (out_last)
  );

  // Zigzag reference built by walking anti-diagonals, alternating direction.
  task automatic build_zz_ref();
    int pos = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[pos] = r * 8 + (s - r); pos++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[pos] = r * 8 + (s - r); pos++; end
      end
    end
  endtask

  function automatic logic [7:0] coef_of(int b, int addr);
    return 8'((addr * 7 + b * 29 + 3) & 255);
  endfunction

  function automatic logic [63:0] make_row(int b, int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[63-8*c -: 8] = coef_of(b, r * 8 + c);
    return v;
  endfunction

  function automatic logic [63:0] raster_row(int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[63-8*c -: 8] = 8'(r * 8 + c);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic send_row(input logic [63:0] row);
    int n = 0;
    in_valid = 1'b1;
    in = row;
    while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_row_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Drains one block, checking every beat against the model; b<0 means raster data.
  task automatic drain_block(input int b, input string name);
    logic [7:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      exp = (b < 0) ? 8'(zz_ref[i]) : coef_of(b, zz_ref[i]);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'(i) || out !== exp || out_last !== (i == 63)) begin
        errors++;
        $display("FAIL %s beat %0d: valid=%b idx=%0d out=%h last=%b required valid=1 idx=%0d out=%h last=%b",
                 name, i, out_valid, out_index, out, out_last, i, exp, (i == 63));
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0;
    step(); step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 8'h00 || out_index !== 6'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out=%h idx=%0d last=%b required 1 0 00 0 0",
               in_ready, out_valid, out, out_index, out_last);
    end
`ifdef ZZ_LAST_NZ_EN
    checks++;
    if (out_last_nz !== 6'd0 || out_all_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_last_nz: last_nz=%0d all_zero=%b required 0 0", out_last_nz, out_all_zero);
    end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_raster();
    logic [7:0] cap [64];
    int head [8] = '{0, 1, 8, 16, 9, 2, 3, 10};
    out_ready = 1'b0;
    for (int r = 0; r < 7; r++) send_row(raster_row(r));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL raster_early_valid: out_valid=%b required 0 after 7 rows", out_valid);
    end
    send_row(raster_row(7));
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL raster_latency: out_valid=%b required 1 the cycle after row 8", out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cap[i] = out;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 6'(i) || out !== 8'(zz_ref[i]) || out_last !== (i == 63)) begin
        errors++;
        $display("FAIL raster beat %0d: valid=%b idx=%0d out=%0d last=%b required 1 %0d %0d %b",
                 i, out_valid, out_index, out, out_last, i, zz_ref[i], (i == 63));
      end
      step();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap[i] !== 8'(head[i])) begin
        errors++; $display("FAIL raster_head pos %0d: out=%0d required %0d", i, cap[i], head[i]);
      end
    end
    checks++;
    if (cap[62] !== 8'd62 || cap[63] !== 8'd63) begin
      errors++; $display("FAIL raster_tail: out=%0d,%0d required 62,63", cap[62], cap[63]);
    end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++; $display("FAIL raster_drained: out_valid=%b out_last=%b required 0 0", out_valid, out_last);
    end
  endtask

  task automatic test_back_to_back();
    int rows_sent = 0, beats = 0, cyc = 0;
    int fall_rows = -1, fall_cyc = -1, rise_cyc = -1, last64_cyc = -1, last64_rows = -1;
    logic prev_ready = 1'b1;
    logic wr, rd;
    logic [7:0] exp;
    apply_reset();
    out_ready = 1'b1;
    while (beats < 192 && cyc < 600) begin
      in_valid = (rows_sent < 24);
      in = make_row(rows_sent / 8, rows_sent % 8);
      if (prev_ready && !in_ready && fall_cyc < 0) begin fall_cyc = cyc; fall_rows = rows_sent; end
      if (!prev_ready && in_ready && fall_cyc >= 0 && rise_cyc < 0) rise_cyc = cyc;
      wr = in_valid && in_ready;
      rd = out_valid && out_ready;
      if (rd) begin
        exp = coef_of(beats / 64, zz_ref[beats % 64]);
        checks++;
        if (out !== exp || out_index !== 6'(beats % 64) || out_last !== (beats % 64 == 63)) begin
          errors++;
          $display("FAIL b2b beat %0d: out=%h idx=%0d last=%b required %h %0d %b",
                   beats, out, out_index, out_last, exp, beats % 64, (beats % 64 == 63));
        end
        if (beats == 63) begin last64_cyc = cyc; last64_rows = rows_sent; end
      end
      prev_ready = in_ready;
      step();
      cyc++;
      if (wr) rows_sent++;
      if (rd) beats++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (beats != 192) begin errors++; $display("FAIL b2b_timeout: beats=%0d required 192", beats); end
    checks++;
    if (fall_rows != 16) begin errors++; $display("FAIL b2b_ready_fall: rows at fall=%0d required 16", fall_rows); end
    checks++;
    if (last64_rows != 16) begin errors++; $display("FAIL b2b_overlap: rows at 64th beat=%0d required 16", last64_rows); end
    checks++;
    if (rise_cyc != last64_cyc + 1) begin
      errors++; $display("FAIL b2b_ready_rise: rise cycle=%0d required %0d", rise_cyc, last64_cyc + 1);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(make_row(6, r));
    for (int r = 0; r < 7; r++) send_row(make_row(7, r));
    out_ready = 1'b1;
    repeat (63) step();
    out_ready = 1'b0;
    checks++;
    if (out_index !== 6'd63 || out_last !== 1'b1) begin
      errors++; $display("FAIL simul_setup: idx=%0d last=%b required 63 1", out_index, out_last);
    end
    in_valid = 1'b1; in = make_row(7, 7); out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 6'd0 || out !== coef_of(7, 0) || in_ready !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge: valid=%b idx=%0d out=%h in_ready=%b last=%b required 1 0 %h 1 0",
               out_valid, out_index, out, in_ready, out_last, coef_of(7, 0));
    end
    drain_block(7, "simul_drain");
  endtask

  task automatic test_throttle();
    int rows_sent = 0, beats = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_out = '0;
    logic [5:0] prev_idx = '0;
    logic wr, rd;
    logic [7:0] exp;
    apply_reset();
    while (beats < 256 && cyc < 3000) begin
      in_valid = (rows_sent < 32) && ($urandom_range(0, 3) != 0);
      in = make_row(10 + rows_sent / 8, rows_sent % 8);
      out_ready = ($urandom_range(0, 1) == 1);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out !== prev_out || out_index !== prev_idx) begin
          errors++;
          $display("FAIL throttle_stall cyc %0d: valid=%b out=%h idx=%0d required 1 %h %0d",
                   cyc, out_valid, out, out_index, prev_out, prev_idx);
        end
      end
      wr = in_valid && in_ready;
      rd = out_valid && out_ready;
      if (rd) begin
        exp = coef_of(10 + beats / 64, zz_ref[beats % 64]);
        checks++;
        if (out !== exp || out_index !== 6'(beats % 64) || out_last !== (beats % 64 == 63)) begin
          errors++;
          $display("FAIL throttle beat %0d: out=%h idx=%0d last=%b required %h %0d %b",
                   beats, out, out_index, out_last, exp, beats % 64, (beats % 64 == 63));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = out;
      prev_idx = out_index;
      step();
      cyc++;
      if (wr) rows_sent++;
      if (rd) beats++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (beats != 256 || out_valid !== 1'b0) begin
      errors++; $display("FAIL throttle_count: beats=%0d valid=%b required 256 0", beats, out_valid);
    end
  endtask

  task automatic test_signed();
    logic [7:0] cap [64];
    apply_reset();
    out_ready = 1'b0;
    send_row(64'h80FF7F0000000000);
    for (int r = 1; r < 8; r++) send_row(64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin cap[i] = out; step(); end
    out_ready = 1'b0;
    checks++;
    if (cap[0] !== 8'h80 || cap[1] !== 8'hFF || cap[5] !== 8'h7F || cap[2] !== 8'h00) begin
      errors++;
      $display("FAIL signed: pos0=%h pos1=%h pos5=%h pos2=%h required 80 ff 7f 00", cap[0], cap[1], cap[5], cap[2]);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(make_row(3, r));
    for (int r = 0; r < 8; r++) send_row(make_row(4, r));
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_both_full: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    repeat (20) step();
    out_ready = 1'b0;
    checks++;
    if (out_index !== 6'd20 || out !== coef_of(3, zz_ref[20])) begin
      errors++; $display("FAIL mid_position: idx=%0d out=%h required 20 %h", out_index, out, coef_of(3, zz_ref[20]));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 6'd0 || out !== 8'h00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b in_ready=%b idx=%0d out=%h last=%b required 0 1 0 00 0",
               out_valid, in_ready, out_index, out, out_last);
    end
    step();
    reset = 1'b1;
    step();
    for (int r = 0; r < 8; r++) send_row(make_row(5, r));
    drain_block(5, "mid_new_block");
  endtask

`ifdef ZZ_LAST_NZ_EN
  task automatic test_last_nz();
    apply_reset();
    out_ready = 1'b0;
    // (0,0)=5 is raster 0; (2,1)=-3 is raster 17, zigzag position 8.
    for (int r = 0; r < 8; r++) begin
      if (r == 0) send_row(64'h0500000000000000);
      else if (r == 2) send_row(64'h00FD000000000000);
      else send_row(64'h0);
    end
    checks++;
    if (out_last_nz !== 6'd8 || out_all_zero !== 1'b0) begin
      errors++; $display("FAIL last_nz_sparse: last_nz=%0d all_zero=%b required 8 0", out_last_nz, out_all_zero);
    end
    out_ready = 1'b1; repeat (64) step(); out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(64'h0);
    checks++;
    if (out_last_nz !== 6'd0 || out_all_zero !== 1'b1) begin
      errors++; $display("FAIL last_nz_zero: last_nz=%0d all_zero=%b required 0 1", out_last_nz, out_all_zero);
    end
    out_ready = 1'b1; repeat (64) step(); out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row((r == 7) ? 64'h0000000000000001 : 64'h0);
    checks++;
    if (out_last_nz !== 6'd63 || out_all_zero !== 1'b0) begin
      errors++; $display("FAIL last_nz_reuse: last_nz=%0d all_zero=%b required 63 0", out_last_nz, out_all_zero);
    end
    out_ready = 1'b1; repeat (64) step(); out_ready = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0;
    build_zz_ref();
    test_reset();
    test_raster();
    test_back_to_back();
    test_simultaneous();
    test_throttle();
    test_signed();
    test_reset_mid_drain();
`ifdef ZZ_LAST_NZ_EN
    test_last_nz();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
